// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - issue, commit, flush and operand-query bundle for reg_file
interface reg_file_if #(
  parameter int ROB_LOG = 4
);
  logic               issue_valid;
  logic [4:0]         issue_dest;
  logic [ROB_LOG-1:0] issue_RobId;
  logic               reg_enable;
  logic [4:0]         reg_index;
  logic [ROB_LOG-1:0] reg_RobId;
  logic [31:0]        reg_value;
  logic               jump_flag;
  logic [4:0]         rs1_index;
  logic [4:0]         rs2_index;
  logic               rs1_busy;
  logic               rs2_busy;
  logic [31:0]        rs1_value;
  logic [31:0]        rs2_value;
  logic [ROB_LOG-1:0] rs1_RobId;
  logic [ROB_LOG-1:0] rs2_RobId;

  modport master (
    output issue_valid, issue_dest, issue_RobId,
    output reg_enable, reg_index, reg_RobId, reg_value,
    output jump_flag, rs1_index, rs2_index,
    input  rs1_busy, rs2_busy, rs1_value, rs2_value, rs1_RobId, rs2_RobId
  );

  modport slave (
    input  issue_valid, issue_dest, issue_RobId,
    input  reg_enable, reg_index, reg_RobId, reg_value,
    input  jump_flag, rs1_index, rs2_index,
    output rs1_busy, rs2_busy, rs1_value, rs2_value, rs1_RobId, rs2_RobId
  );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - committed integer registers with per-register rename tags
module reg_file #(
  parameter int ROB_LOG = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  reg_file_if.slave      bus
);
  typedef struct packed {
    logic               busy;
    logic [ROB_LOG-1:0] robid;
    logic [31:0]        value;
  } query_t;

  logic [31:0]        value_q [32];
  logic [31:0]        value_d [32];
  logic [ROB_LOG-1:0] tag_q   [32];
  logic [ROB_LOG-1:0] tag_d   [32];
  logic [31:0]        busy_q;
  logic [31:0]        busy_d;

  logic commit_en;
  logic rename_en;

  assign commit_en = bus.reg_enable && (bus.reg_index != 5'd0);
  assign rename_en = bus.issue_valid && (bus.issue_dest != 5'd0) && !bus.jump_flag;

  // Rename is applied after commit so a same-register rename overrides the busy clear.
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    if (commit_en) begin
      value_d[bus.reg_index] = bus.reg_value;
      if (busy_q[bus.reg_index] && (tag_q[bus.reg_index] == bus.reg_RobId))
        busy_d[bus.reg_index] = 1'b0;
    end
    if (bus.jump_flag) begin
      busy_d = '0;
    end else if (rename_en) begin
      busy_d[bus.issue_dest] = 1'b1;
      tag_d[bus.issue_dest]  = bus.issue_RobId;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      busy_q <= '0;
    end else if (rdy) begin
      value_q <= value_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
    end
  end

  // A matching commit forwards its value in the same cycle; renames this cycle are not seen.
  function automatic query_t lookup(input logic [4:0] idx);
    query_t r;
    r.busy  = 1'b0;
    r.robid = tag_q[idx];
    r.value = value_q[idx];
    if (idx == 5'd0) begin
      r.value = '0;
    end else if (busy_q[idx]) begin
      if (bus.reg_enable && (bus.reg_index == idx) && (bus.reg_RobId == tag_q[idx]))
        r.value = bus.reg_value;
      else
        r.busy = 1'b1;
    end
    return r;
  endfunction

  query_t q1;
  query_t q2;

  always_comb begin
    q1 = lookup(bus.rs1_index);
    q2 = lookup(bus.rs2_index);
  end

  assign bus.rs1_busy  = q1.busy;
  assign bus.rs1_RobId = q1.robid;
  assign bus.rs1_value = q1.value;
  assign bus.rs2_busy  = q2.busy;
  assign bus.rs2_RobId = q2.robid;
  assign bus.rs2_value = q2.value;
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
module tb_reg_file;
  localparam int RL = 4;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   n_checks = 0;
  int   n_fail   = 0;

  reg_file_if #(.ROB_LOG(RL)) bus ();

  reg_file #(.ROB_LOG(RL)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_dest  = '0;
    bus.issue_RobId = '0;
    bus.reg_enable  = 1'b0;
    bus.reg_index   = '0;
    bus.reg_RobId   = '0;
    bus.reg_value   = '0;
    bus.jump_flag   = 1'b0;
  endtask

  task automatic rename(input logic [4:0] d, input logic [RL-1:0] t);
    bus.issue_valid = 1'b1;
    bus.issue_dest  = d;
    bus.issue_RobId = t;
    tick();
    idle();
  endtask

  task automatic commit(input logic [4:0] d, input logic [RL-1:0] t, input logic [31:0] v);
    bus.reg_enable = 1'b1;
    bus.reg_index  = d;
    bus.reg_RobId  = t;
    bus.reg_value  = v;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b1;
    idle();
    bus.rs1_index = 5'd0;
    bus.rs2_index = 5'd0;
    tick();
    tick();
    rst = 1'b0;
    bus.rs1_index = 5'd5;
    bus.rs2_index = 5'd0;
    #1;
    n_checks++;
    if ({bus.rs1_busy, bus.rs1_value} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_rs1 got busy=%0b value=%h want busy=0 value=0", bus.rs1_busy, bus.rs1_value);
    end
    n_checks++;
    if ({bus.rs2_busy, bus.rs2_value} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_rs2 got busy=%0b value=%h want busy=0 value=0", bus.rs2_busy, bus.rs2_value);
    end
    bus.rs1_index = 5'd31;
    #1;
    n_checks++;
    if ({bus.rs1_busy, bus.rs1_value} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_x31 got busy=%0b value=%h want busy=0 value=0", bus.rs1_busy, bus.rs1_value);
    end
    commit(5'd0, 4'd0, 32'hDEAD);
    rename(5'd0, 4'd3);
    bus.rs1_index = 5'd0;
    #1;
    n_checks++;
    if ({bus.rs1_busy, bus.rs1_value} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL x0_hardwired got busy=%0b value=%h want busy=0 value=0", bus.rs1_busy, bus.rs1_value);
    end
  endtask

  task automatic test_rename_bypass();
    rename(5'd3, 4'd4);
    bus.rs1_index = 5'd3;
    #1;
    n_checks++;
    if ({bus.rs1_busy, bus.rs1_RobId} !== {1'b1, 4'd4}) begin
      n_fail++;
      $display("FAIL rename_x3 got busy=%0b robid=%0d want busy=1 robid=4", bus.rs1_busy, bus.rs1_RobId);
    end
    bus.reg_enable = 1'b1;
    bus.reg_index  = 5'd3;
    bus.reg_RobId  = 4'd4;
    bus.reg_value  = 32'h1234;
    #1;
    n_checks++;
    if ({bus.rs1_busy, bus.rs1_value} !== {1'b0, 32'h1234}) begin
      n_fail++;
      $display("FAIL bypass_x3 got busy=%0b value=%h want busy=0 value=1234", bus.rs1_busy, bus.rs1_value);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if ({bus.rs1_busy, bus.rs1_value} !== {1'b0, 32'h1234}) begin
      n_fail++;
      $display("FAIL commit_x3 got busy=%0b value=%h want busy=0 value=1234", bus.rs1_busy, bus.rs1_value);
    end
  endtask

  task automatic test_stale_commit();
    rename(5'd7, 4'd2);
    rename(5'd7, 4'd5);
    bus.rs2_index  = 5'd7;
    bus.reg_enable = 1'b1;
    bus.reg_index  = 5'd7;
    bus.reg_RobId  = 4'd2;
    bus.reg_value  = 32'hAA;
    #1;
    n_checks++;
    if ({bus.rs2_busy, bus.rs2_RobId} !== {1'b1, 4'd5}) begin
      n_fail++;
      $display("FAIL stale_no_bypass got busy=%0b robid=%0d want busy=1 robid=5", bus.rs2_busy, bus.rs2_RobId);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if ({bus.rs2_busy, bus.rs2_RobId} !== {1'b1, 4'd5}) begin
      n_fail++;
      $display("FAIL stale_keeps_busy got busy=%0b robid=%0d want busy=1 robid=5", bus.rs2_busy, bus.rs2_RobId);
    end
    commit(5'd7, 4'd5, 32'hBB);
    #1;
    n_checks++;
    if ({bus.rs2_busy, bus.rs2_value} !== {1'b0, 32'hBB}) begin
      n_fail++;
      $display("FAIL young_commit_x7 got busy=%0b value=%h want busy=0 value=bb", bus.rs2_busy, bus.rs2_value);
    end
  endtask

  task automatic test_same_cycle();
    bus.rs1_index   = 5'd9;
    bus.reg_enable  = 1'b1;
    bus.reg_index   = 5'd9;
    bus.reg_RobId   = 4'd1;
    bus.reg_value   = 32'h55;
    bus.issue_valid = 1'b1;
    bus.issue_dest  = 5'd9;
    bus.issue_RobId = 4'd6;
    tick();
    idle();
    #1;
    n_checks++;
    if ({bus.rs1_busy, bus.rs1_RobId} !== {1'b1, 4'd6}) begin
      n_fail++;
      $display("FAIL same_cycle_rename got busy=%0b robid=%0d want busy=1 robid=6", bus.rs1_busy, bus.rs1_RobId);
    end
    commit(5'd9, 4'd6, 32'h66);
    #1;
    n_checks++;
    if ({bus.rs1_busy, bus.rs1_value} !== {1'b0, 32'h66}) begin
      n_fail++;
      $display("FAIL same_cycle_commit got busy=%0b value=%h want busy=0 value=66", bus.rs1_busy, bus.rs1_value);
    end
  endtask

  task automatic test_flush();
    commit(5'd2, 4'd0, 32'h22);
    commit(5'd10, 4'd0, 32'h1010);
    rename(5'd1, 4'd1);
    rename(5'd2, 4'd2);
    rename(5'd10, 4'd3);
    bus.jump_flag   = 1'b1;
    bus.reg_enable  = 1'b1;
    bus.reg_index   = 5'd1;
    bus.reg_RobId   = 4'd1;
    bus.reg_value   = 32'h77;
    bus.issue_valid = 1'b1;
    bus.issue_dest  = 5'd5;
    bus.issue_RobId = 4'd7;
    tick();
    idle();
    bus.rs1_index = 5'd1;
    bus.rs2_index = 5'd2;
    #1;
    n_checks++;
    if ({bus.rs1_busy, bus.rs1_value} !== {1'b0, 32'h77}) begin
      n_fail++;
      $display("FAIL flush_x1 got busy=%0b value=%h want busy=0 value=77", bus.rs1_busy, bus.rs1_value);
    end
    n_checks++;
    if ({bus.rs2_busy, bus.rs2_value} !== {1'b0, 32'h22}) begin
      n_fail++;
      $display("FAIL flush_x2 got busy=%0b value=%h want busy=0 value=22", bus.rs2_busy, bus.rs2_value);
    end
    bus.rs1_index = 5'd10;
    bus.rs2_index = 5'd5;
    #1;
    n_checks++;
    if ({bus.rs1_busy, bus.rs1_value} !== {1'b0, 32'h1010}) begin
      n_fail++;
      $display("FAIL flush_x10 got busy=%0b value=%h want busy=0 value=1010", bus.rs1_busy, bus.rs1_value);
    end
    n_checks++;
    if (bus.rs2_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drops_rename got busy=%0b want busy=0", bus.rs2_busy);
    end
  endtask

  task automatic test_rdy_stall();
    bus.rs1_index   = 5'd4;
    bus.rs2_index   = 5'd11;
    rdy             = 1'b0;
    bus.reg_enable  = 1'b1;
    bus.reg_index   = 5'd4;
    bus.reg_RobId   = 4'd0;
    bus.reg_value   = 32'h9;
    bus.issue_valid = 1'b1;
    bus.issue_dest  = 5'd11;
    bus.issue_RobId = 4'd3;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({bus.rs1_busy, bus.rs1_value, bus.rs2_busy} !== {1'b0, 32'h0, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_cycle%0d got x4 busy=%0b value=%h x11 busy=%0b want 0/0/0",
                 c, bus.rs1_busy, bus.rs1_value, bus.rs2_busy);
      end
    end
    rdy = 1'b1;
    tick();
    idle();
    #1;
    n_checks++;
    if ({bus.rs1_busy, bus.rs1_value} !== {1'b0, 32'h9}) begin
      n_fail++;
      $display("FAIL resume_commit_x4 got busy=%0b value=%h want busy=0 value=9", bus.rs1_busy, bus.rs1_value);
    end
    n_checks++;
    if ({bus.rs2_busy, bus.rs2_RobId} !== {1'b1, 4'd3}) begin
      n_fail++;
      $display("FAIL resume_rename_x11 got busy=%0b robid=%0d want busy=1 robid=3", bus.rs2_busy, bus.rs2_RobId);
    end
  endtask

  task automatic test_reset_midflight();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.rs1_busy, bus.rs1_value, bus.rs2_busy, bus.rs2_value} !== {1'b0, 32'h0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL midflight_reset got x4 %0b/%h x11 %0b/%h want all zero",
               bus.rs1_busy, bus.rs1_value, bus.rs2_busy, bus.rs2_value);
    end
  endtask

  initial begin
    test_reset();
    test_rename_bypass();
    test_stale_commit();
    test_same_cycle();
    test_flush();
    test_rdy_stall();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with rename tags for the out-of-order core. It sits directly downstream of the reorder buffer and holds the 32 committed integer registers. It applies the ROB's in-order commit writes and records, per register, the ROB entry that will produce that register's next value. The issue stage queries two source operands per cycle and receives either a ready value or the ROB tag to wait on.

## Interface
- `ROB_LOG`: from `config.v`; tag width; `ROB_SIZE = 2^ROB_LOG`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rdy`  in  1  global ready; low freezes all state.
- `issue_valid`  in  1  an instruction with a destination is issued this cycle.
- `issue_dest`  in  5  destination register of the issued instruction.
- `issue_RobId`  in  ROB_LOG  ROB entry allocated to the issued instruction.
- `reg_enable`  in  1  ROB commit write strobe.
- `reg_index`  in  5  commit destination.
- `reg_RobId`  in  ROB_LOG  ROB entry being committed.
- `reg_value`  in  32  commit value.
- `jump_flag`  in  1  ROB flush (mispredict/jump) strobe.
- `rs1_index`, `rs2_index`  in  5  issue-stage source queries.
- `rs1_busy`, `rs2_busy`  out  1  operand not yet available.
- `rs1_value`, `rs2_value`  out  32  operand value; valid when busy=0.
- `rs1_RobId`, `rs2_RobId`  out  ROB_LOG  producing ROB entry; valid when busy=1.

## Operation
- Per register state:
  - `value[32]` holds the 32-bit committed value.
  - `busy` is set while a younger in-flight producer exists.
  - `tag` is ROB_LOG bits and names that producer.
- Register x0 is hard-wired:
  - It reads as value 0 and busy 0.
  - Commits and renames to x0 are ignored.
- Update priority per clock edge:
  1. `rst` has highest priority.
  2. When `rdy` is low, all state holds, including any pending commit.
  3. Otherwise, the normal update below applies.
- Commit, when `reg_enable` and `reg_index != 0`:
  - `value[reg_index] <= reg_value` always.
  - `busy` is cleared only if `busy && tag == reg_RobId`.
  - If the tag differs, a younger rename is outstanding; busy and tag are kept.
- Rename, when `issue_valid` and `issue_dest != 0` and `jump_flag` is low:
  - `busy[issue_dest] <= 1`.
  - `tag[issue_dest] <= issue_RobId`.
- Commit and rename to the same register in the same cycle:
  - The value is written.
  - The rename wins: busy=1 and tag=issue_RobId.
- Flush, when `jump_flag` is high:
  - All busy bits clear.
  - A commit presented in the same cycle is still written; the ROB asserts both together.
  - `issue_valid` is ignored in that cycle.
- Queries are combinational for each port p:
  - If `rs_p_index == 0`: busy=0 and value=0.
  - Else if `busy[idx]` and a commit this cycle matches (`reg_enable`, `reg_index == idx`, `reg_RobId == tag[idx]`): busy=0 and value=`reg_value` (commit bypass).
  - Else if `busy[idx]`: busy=1, RobId=tag[idx], value=`value[idx]` (don't-care).
  - Else: busy=0 and value=`value[idx]`.
- The query path does not see this cycle's rename. The issue stage resolves same-cycle dependences itself.

## Timing
- Reset: all 32 values are 0, all busy bits are 0, and all tags are 0. Outputs therefore read value 0 and busy 0 for any index.
- Commit and rename take effect at the clock edge. They are visible to queries from the next cycle.
- The commit bypass gives zero-cycle visibility of the committing value to the query outputs.
- Flush completes in one edge; the cycle after `jump_flag`, no register is busy.
- `rdy` low with `reg_enable` held high applies the commit exactly once, on the first edge with rdy high. The write is idempotent regardless.
- Reset in mid-flight discards all tags and values. There is no partial state.

## Test plan
- Reset, then query rs1=5 and rs2=0 → busy 0/0, value 0/0. Commit x0 := 0xDEAD → x0 still reads 0.
- Rename x3 with tag 4; next cycle query x3 → busy 1, RobId 4. Commit (x3, tag 4, 0x1234) → the same cycle reads busy 0, value 0x1234 (bypass). The next cycle reads busy 0, value 0x1234.
- Rename x7 with tag 2, then rename x7 with tag 5. Commit (x7, tag 2, 0xAA) → value 0xAA is stored, x7 stays busy with RobId 5. Commit tag 5 with 0xBB → not busy, 0xBB.
- Same cycle: commit (x9, tag 1, 0x55) and rename x9 with tag 6 → next cycle busy 1, RobId 6. After commit of tag 6 with 0x66 → 0x66.
- Rename x1, x2, x10 with tags 1, 2, 3. Flush together with commit (x1, tag 1, 0x77) → the next cycle reads x1=0x77, x2 and x10 not busy with their old values. A rename asserted in the flush cycle is dropped.
- Set rdy low while a commit (x4, tag 0, 0x9) and a rename are presented → state unchanged for 3 cycles. Raise rdy → both are applied on the first edge.
